// File: rtl/matrix_pkg.sv
// Shared widths and FSM state codes for the matrix data-memory read sequencer.
package matrix_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 100;
  localparam int DIM_W  = 4;
  localparam int EXT_W  = ADDR_W + DIM_W;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
endpackage

// File: rtl/matrix_addr_gen.sv
// Multiplier-free address walker for an RxC row-major matrix: running pointer,
// r/c counters, column-start register, last-element detect and bounds check.
module matrix_addr_gen
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_init,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [DIM_W-1:0]  i_rows,
  input  logic [DIM_W-1:0]  i_cols,
  input  logic              i_col_major,
  output logic              o_ok,
  output logic [ADDR_W-1:0] o_ptr,
  output logic [ADDR_W-1:0] o_base,
  output logic              o_last
);
  logic [EXT_W-1:0]  w_end;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_col_start;
  logic [DIM_W-1:0]  r_rows;
  logic [DIM_W-1:0]  r_cols;
  logic [DIM_W-1:0]  r_r;
  logic [DIM_W-1:0]  r_c;
  logic              r_col_major;
  logic              w_r_wrap;
  logic              w_c_wrap;

  // Wide end-address check; once it passes, every pointer value fits ADDR_W.
  assign w_end = EXT_W'(i_base) + EXT_W'(i_rows) * EXT_W'(i_cols);
  assign o_ok  = (i_rows != '0) && (i_cols != '0) && (w_end <= EXT_W'(DEPTH));

  assign w_r_wrap = (r_r == r_rows - DIM_W'(1));
  assign w_c_wrap = (r_c == r_cols - DIM_W'(1));
  assign o_last   = w_r_wrap && w_c_wrap;
  assign o_ptr    = r_ptr;
  assign o_base   = r_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_base      <= '0;
      r_col_start <= '0;
      r_rows      <= '0;
      r_cols      <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_col_major <= 1'b0;
    end else if (i_init) begin
      r_ptr       <= i_base;
      r_base      <= i_base;
      r_col_start <= i_base;
      r_rows      <= i_rows;
      r_cols      <= i_cols;
      r_r         <= '0;
      r_c         <= '0;
      r_col_major <= i_col_major;
    end else if (i_step) begin
      if (r_col_major) begin
        if (w_r_wrap) begin
          r_r         <= '0;
          r_c         <= r_c + DIM_W'(1);
          r_col_start <= r_col_start + ADDR_W'(1);
          r_ptr       <= r_col_start + ADDR_W'(1);
        end else begin
          r_r   <= r_r + DIM_W'(1);
          r_ptr <= r_ptr + ADDR_W'(r_cols);
        end
      end else begin
        r_ptr <= r_ptr + ADDR_W'(1);
        if (w_c_wrap) begin
          r_c <= '0;
          r_r <= r_r + DIM_W'(1);
        end else begin
          r_c <= r_c + DIM_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/matrix_mem_reader.sv
// Streams an RxC matrix from a combinational-read memory in row- or column-major
// order over valid/ready; FSM and output register live here, addressing in matrix_addr_gen.
module matrix_mem_reader
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [DIM_W-1:0]  i_rows,
  input  logic [DIM_W-1:0]  i_cols,
  input  logic              i_col_major,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  state_t            r_state;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              w_idle_start;
  logic              w_accept;
  logic              w_reject;
  logic              w_load;
  logic              w_ok;
  logic              w_last;
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] w_base;

  // A start coinciding with the done pulse is not taken; it must come a cycle later.
  assign w_idle_start = (r_state == ST_IDLE) && i_start && !r_done;
  assign w_accept     = w_idle_start && w_ok;
  assign w_reject     = w_idle_start && !w_ok;
  assign w_load       = (r_state == ST_RUN) && (!r_out_valid || i_out_ready);

  matrix_addr_gen u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_init      (w_accept),
    .i_step      (w_load),
    .i_base      (i_base),
    .i_rows      (i_rows),
    .i_cols      (i_cols),
    .i_col_major (i_col_major),
    .o_ok        (w_ok),
    .o_ptr       (w_ptr),
    .o_base      (w_base),
    .o_last      (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else if (w_reject) begin
            r_err <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_load) begin
            r_out_data  <= i_mem_rdata;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last;
            if (w_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_mem_addr  = (r_state == ST_RUN) ? w_ptr : w_base;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
endmodule

// File: tb/tb_matrix_mem_reader.sv
// Scoreboard bench for matrix_mem_reader: a behavioural model queues expected
// elements, an independent monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_matrix_mem_reader;
  import matrix_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic [DIM_W-1:0]  rows = '0;
  logic [DIM_W-1:0]  cols = '0;
  logic              col_major = 1'b0;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, busy_cnt = 0, valid_cnt = 0, acc_cnt = 0;
  int last_done_cyc = 0, last_err_cyc = 0;
  int rdy_mode = 0, rdy_phase = 0;

  always #5 clk = ~clk;

  assign mem_rdata = (int'(mem_addr) < DEPTH) ? mem[mem_addr] : 32'hDEAD_BEEF;

  matrix_mem_reader dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_base      (base),
    .i_rows      (rows),
    .i_cols      (cols),
    .i_col_major (col_major),
    .o_mem_addr  (mem_addr),
    .i_mem_rdata (mem_rdata),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer ready pattern: 0 always, 1 = 1,0,0 repeating, 2 random, 3 never.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: stall stability, handshake scoreboard and event counters.
  initial begin : monitor
    exp_t e;
    logic prev_stall;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid), 1);
          chk("hold_data", out_data, prev_data);
          chk("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid) valid_cnt++;
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        if (err) begin
          err_cnt++;
          last_err_cyc = cyc;
        end
        if (out_valid && out_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_elem: got 0x%0h, expected no element (cycle %0d)", out_data, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("elem_data", out_data, e.d);
            chk("elem_last", 32'(out_last), 32'(e.l));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
      end
    end
  end

  // Reference model: element (i,j) lives at b + i*c + j; order picks the loop nesting.
  function automatic void push_model(input int b, input int r, input int c, input bit cm);
    exp_t e;
    int n;
    n = 0;
    if (cm) begin
      for (int j = 0; j < c; j++)
        for (int i = 0; i < r; i++) begin
          n++;
          e.d = mem[b + i * c + j];
          e.l = (n == r * c);
          exp_q.push_back(e);
        end
    end else begin
      for (int i = 0; i < r; i++)
        for (int j = 0; j < c; j++) begin
          n++;
          e.d = mem[b + i * c + j];
          e.l = (n == r * c);
          exp_q.push_back(e);
        end
    end
  endfunction

  task automatic recover();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    n_chk++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL %s: got no done after %0d cycles, expected a done pulse", name, k);
      recover();
    end
  endtask

  task automatic do_xfer(input int b, input int r, input int c, input bit cm, input int mode);
    bit legal;
    int t0, d0, e0, b0, v0, n;
    n = r * c;
    legal = (r >= 1) && (c >= 1) && (b + n <= DEPTH);
    rdy_mode = mode;
    if (legal) push_model(b, r, c, cm);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = ADDR_W'(b);
    rows = DIM_W'(r);
    cols = DIM_W'(c);
    col_major = cm;
    t0 = cyc;
    d0 = done_cnt;
    e0 = err_cnt;
    b0 = busy_cnt;
    v0 = valid_cnt;
    @(posedge clk);
    #1;
    // Scramble the parameter inputs so any failure to latch them shows up.
    start = 1'b0;
    base = ADDR_W'($urandom);
    rows = DIM_W'($urandom);
    cols = DIM_W'($urandom);
    col_major = 1'($urandom);
    if (legal) begin
      wait_done(d0, "xfer_done");
      #1;
      chk("idle_addr", 32'(mem_addr), b);
      if (mode == 0) begin
        chk("done_latency", last_done_cyc - t0, 2 + n);
        chk("busy_cycles", busy_cnt - b0, n + 1);
      end
      repeat (2) @(posedge clk);
      #1;
      chk("done_pulses", done_cnt - d0, 1);
      chk("queue_empty", exp_q.size(), 0);
    end else begin
      repeat (3) @(posedge clk);
      #1;
      chk("err_pulses", err_cnt - e0, 1);
      chk("err_latency", last_err_cyc - t0, 1);
      chk("rej_busy", busy_cnt - b0, 0);
      chk("rej_valid", valid_cnt - v0, 0);
      chk("rej_done", done_cnt - d0, 0);
    end
  endtask

  initial begin
    int d0, e0, a0, k, b, r, c;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_xfer(10, 2, 3, 1'b0, 0);
    do_xfer(10, 2, 3, 1'b1, 0);
    do_xfer(0, 3, 3, 1'b0, 1);
    do_xfer(95, 2, 3, 1'b0, 0);
    do_xfer(0, 0, 3, 1'b0, 0);
    do_xfer(0, 3, 0, 1'b1, 0);
    do_xfer(0, 10, 10, 1'b1, 2);
    do_xfer(0, 15, 6, 1'b0, 0);
    do_xfer(4, 6, 15, 1'b1, 1);

    // Abort after exactly two accepted elements.
    rdy_mode = 0;
    push_model(0, 3, 3, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = '0;
    rows = DIM_W'(3);
    cols = DIM_W'(3);
    col_major = 1'b0;
    d0 = done_cnt;
    a0 = acc_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (acc_cnt - a0 < 2 && k < 50) begin
      @(negedge clk);
      #2;
      k++;
    end
    rst = 1'b1;
    chk("abort_accepted", acc_cnt - a0, 2);
    chk("abort_remaining", exp_q.size(), 7);
    @(negedge clk);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_addr", 32'(mem_addr), 0);
    @(negedge clk);
    chk("abort_done", 32'(done), 0);
    chk("abort_done_cnt", done_cnt - d0, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_xfer(0, 3, 3, 1'b0, 0);

    // 1x1 at the top word, with a start pulsed while the element sits in DRAIN.
    rdy_mode = 3;
    push_model(99, 1, 1, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    base = ADDR_W'(99);
    rows = DIM_W'(1);
    cols = DIM_W'(1);
    col_major = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_valid", 32'(out_valid), 1);
    chk("drain_addr", 32'(mem_addr), 99);
    chk("drain_busy_high", 32'(busy), 1);
    start = 1'b1;
    base = '0;
    rows = DIM_W'(2);
    cols = DIM_W'(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    rdy_mode = 0;
    wait_done(d0, "drain_done");
    repeat (6) @(posedge clk);
    #1;
    chk("drain_err", err_cnt - e0, 0);
    chk("drain_done_pulses", done_cnt - d0, 1);
    chk("drain_busy_low", 32'(busy), 0);
    chk("drain_queue_empty", exp_q.size(), 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (30) begin
      b = $urandom_range(0, DEPTH - 1);
      r = $urandom_range(0, 7);
      c = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, 20);
        r = $urandom_range(1, 15);
        c = $urandom_range(1, 6);
      end
      do_xfer(b, r, c, 1'($urandom), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test by cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
